// File: rtl/def.sv
// Memory funct3 encodings and access-legality helpers shared by the load/store path.
// Misalignment rules apply only when LSU_MISALIGN_TRAP_EN is defined.
package f3Mem;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic f3_illegal(
    input logic       st,
    input logic [2:0] f3
  );
    if (st)
      return !(f3 == SB || f3 == SH || f3 == SW);
    return (f3 == 3'b011) || (f3 == 3'b110) ||
           (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    if (f3[1:0] == 2'b01)
      return off[0];
    if (f3[1:0] == 2'b10)
      return |off;
    return 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-enable generation, store-data replication and load extraction.
// Purely combinational; misaligned halves/words are aligned down.
module lsu_align
  import f3Mem::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_off;
  logic [31:0] w_sh;
  logic        w_byte;
  logic        w_half;
  logic        w_word;

  assign w_byte = (i_f3[1:0] == LB[1:0]);
  assign w_half = (i_f3[1:0] == LH[1:0]);
  assign w_word = (i_f3[1:0] == LW[1:0]);

  always_comb begin
    w_off   = 2'b00;
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    unique case (1'b1)
      w_byte: begin
        w_off   = i_off;
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      w_half: begin
        w_off   = {i_off[1], 1'b0};
        o_be    = 4'b0011 << {i_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      w_word: o_be = 4'b1111;
      default: ;
    endcase
  end

  assign w_sh = i_rdata >> {w_off, 3'b000};

  always_comb begin
    o_rdata = w_sh;
    unique case (1'b1)
      w_byte: o_rdata = i_f3[2] ?
        {24'h0, w_sh[7:0]} :
        {{24{w_sh[7]}}, w_sh[7:0]};
      w_half: o_rdata = i_f3[2] ?
        {16'h0, w_sh[15:0]} :
        {{16{w_sh[15]}}, w_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one bus transaction per access via req/gnt/rvalid.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halves/words.
module lsu
  import f3Mem::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rdata,
  output logic        exc,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_exc;
  logic        w_fault;
  logic        w_accept;
  logic [3:0]  w_be;
  logic [31:0] w_rep;
  logic [31:0] w_fmt;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_fault = f3_illegal(is_store, funct3) |
                   misaligned(funct3, addr[1:0]);
`else
  assign w_fault = f3_illegal(is_store, funct3);
`endif

  assign w_accept = (r_state == IDLE) && in_valid;

  lsu_align u_align (
    .i_f3    (r_f3),
    .i_off   (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_rep),
    .o_rdata (w_fmt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid)
              w_next = w_fault ? DONE : REQ;
      REQ:  if (bus_gnt)    w_next = WAIT;
      WAIT: if (bus_rvalid) w_next = DONE;
      DONE: if (out_ready)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_exc   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= is_store;
        r_f3    <= funct3;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_exc   <= w_fault;
        r_rdata <= '0;
      end
      if (r_state == WAIT && bus_rvalid && !r_we)
        r_rdata <= w_fmt;
    end
  end

  // Bus outputs are driven only in REQ so they hold steady until grant.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rdata     = '0;
    exc       = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_be    = 4'b0000;
    bus_addr  = '0;
    bus_wdata = '0;
    unique case (r_state)
      IDLE: in_ready = 1'b1;
      REQ: begin
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_be    = w_be;
        bus_addr  = {r_addr[31:2], 2'b00};
        bus_wdata = w_rep;
      end
      DONE: begin
        out_valid = 1'b1;
        exc       = r_exc;
        rdata     = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Directed vector bench for lsu: table of single accesses plus
// hand sequences for stalls, back-pressure and mid-op reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rdata;
  logic        exc;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rdata      (rdata),
    .exc        (exc),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  typedef struct {
    string       nm;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] brd;
    logic        ex;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic st,
    input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] brd,
    input logic ex, input logic [3:0] be,
    input logic [31:0] bwd, input logic [31:0] rd);
    vec_t v;
    v.nm = nm; v.st = st; v.f3 = f3; v.a = a;
    v.wd = wd; v.brd = brd; v.ex = ex; v.be = be;
    v.baddr = {a[31:2], 2'b00};
    v.bwd = bwd; v.rd = rd;
    return v;
  endfunction

  task automatic present(input logic st, input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    in_valid = 1'b1; is_store = st;
    funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.nm, ".in_ready"}, in_ready, 1);
    present(v.st, v.f3, v.a, v.wd);
    if (v.ex) begin
      chk({v.nm, ".c1_out_valid"}, out_valid, 1);
      chk({v.nm, ".exc"}, exc, 1);
      chk({v.nm, ".bus_req"}, bus_req, 0);
      chk({v.nm, ".rdata"}, rdata, 0);
    end else begin
      chk({v.nm, ".c1_bus_req"}, bus_req, 1);
      chk({v.nm, ".out_valid"}, out_valid, 0);
      chk({v.nm, ".bus_we"}, bus_we, v.st);
      chk({v.nm, ".bus_be"}, bus_be, v.be);
      chk({v.nm, ".bus_addr"}, bus_addr, v.baddr);
      if (v.st) chk({v.nm, ".bus_wdata"}, bus_wdata, v.bwd);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk({v.nm, ".c2_bus_req"}, bus_req, 0);
      bus_rvalid = 1'b1; bus_rdata = v.brd;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = '0;
      chk({v.nm, ".c3_out_valid"}, out_valid, 1);
      chk({v.nm, ".exc"}, exc, 0);
      chk({v.nm, ".rdata"}, rdata, v.rd);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.nm, ".next_in_ready"}, in_ready, 1);
    chk({v.nm, ".next_out_valid"}, out_valid, 0);
  endtask

  initial begin
    vecs.push_back(mk("lw_1000", 0, 3'b010, 32'h1000, 0,
      32'hDEADBEEF, 0, 4'b1111, 0, 32'hDEADBEEF));
    vecs.push_back(mk("lb_1003", 0, 3'b000, 32'h1003, 0,
      32'h80FF0000, 0, 4'b1000, 0, 32'hFFFFFF80));
    vecs.push_back(mk("lbu_1003", 0, 3'b100, 32'h1003, 0,
      32'h80FF0000, 0, 4'b1000, 0, 32'h00000080));
    vecs.push_back(mk("sh_2002", 1, 3'b001, 32'h2002,
      32'h1234ABCD, 0, 0, 4'b1100, 32'hABCDABCD, 0));
    vecs.push_back(mk("sb_4001", 1, 3'b000, 32'h4001,
      32'h000000A5, 0, 0, 4'b0010, 32'hA5A5A5A5, 0));
    vecs.push_back(mk("lh_5002", 0, 3'b001, 32'h5002, 0,
      32'h80011234, 0, 4'b1100, 0, 32'hFFFF8001));
    vecs.push_back(mk("lhu_5000", 0, 3'b101, 32'h5000, 0,
      32'h8001F00D, 0, 4'b0011, 0, 32'h0000F00D));
    vecs.push_back(mk("sw_6000", 1, 3'b010, 32'h6000,
      32'hCAFEBABE, 0, 0, 4'b1111, 32'hCAFEBABE, 0));
    vecs.push_back(mk("ld_f3_011", 0, 3'b011, 32'h10, 0,
      32'h12345678, 1, 0, 0, 0));
    vecs.push_back(mk("ld_f3_110", 0, 3'b110, 32'h20, 0,
      32'h12345678, 1, 0, 0, 0));
    vecs.push_back(mk("st_f3_100", 1, 3'b100, 32'h30,
      32'h1, 0, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_3001", 0, 3'b010, 32'h3001, 0,
      32'h11223344, 1, 0, 0, 0));
    vecs.push_back(mk("lh_5003", 0, 3'b001, 32'h5003, 0,
      32'h80011234, 1, 0, 0, 0));
`else
    vecs.push_back(mk("lw_3001", 0, 3'b010, 32'h3001, 0,
      32'h11223344, 0, 4'b1111, 0, 32'h11223344));
    vecs.push_back(mk("lh_5003", 0, 3'b001, 32'h5003, 0,
      32'h80011234, 0, 4'b1100, 0, 32'hFFFF8001));
`endif

    @(negedge clk);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.exc", exc, 0);
    chk("rst.rdata", rdata, 0);
    chk("rst.bus_req", bus_req, 0);
    chk("rst.bus_we", bus_we, 0);
    chk("rst.bus_be", bus_be, 0);
    chk("rst.bus_addr", bus_addr, 0);
    chk("rst.bus_wdata", bus_wdata, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // stray grant and response while idle
    @(negedge clk);
    bus_gnt = 1'b1; bus_rvalid = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    chk("stray.in_ready", in_ready, 1);
    chk("stray.bus_req", bus_req, 0);
    chk("stray.out_valid", out_valid, 0);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i]);

    // SH with grant delayed 3 cycles, late rvalid, back-pressure
    @(negedge clk);
    present(1'b1, 3'b001, 32'h2002, 32'h1234ABCD);
    for (int k = 0; k < 3; k++) begin
      bus_rvalid = (k == 1);
      chk("dly.bus_req", bus_req, 1);
      chk("dly.bus_we", bus_we, 1);
      chk("dly.bus_be", bus_be, 4'b1100);
      chk("dly.bus_addr", bus_addr, 32'h2000);
      chk("dly.bus_wdata", bus_wdata, 32'hABCDABCD);
      @(negedge clk);
    end
    bus_rvalid = 1'b0;
    chk("dly.held_req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    @(negedge clk);
    chk("dly.wait_out_valid", out_valid, 0);
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp.out_valid", out_valid, 1);
      chk("bp.rdata", rdata, 0);
      chk("bp.exc", exc, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.in_ready", in_ready, 1);

    // reset asserted while the request is pending
    present(1'b0, 3'b010, 32'h1000, 0);
    chk("rreq.bus_req_pre", bus_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rreq.bus_req", bus_req, 0);
    chk("rreq.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // reset asserted in WAIT, then a late response
    @(negedge clk);
    present(1'b0, 3'b010, 32'h1000, 0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rwait.bus_req", bus_req, 0);
    chk("rwait.out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = '0;
    chk("rwait.late_in_ready", in_ready, 1);
    chk("rwait.late_out_valid", out_valid, 0);
    chk("rwait.late_bus_req", bus_req, 0);

    // recovery after reset
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
